// File: rtl/serial_sub7.sv
// serial_sub7: bit-serial 7-bit subtractor, d = a - b mod 128.
// One full-adder slice processes one bit per clock (b inverted, carry preset to 1).
// Optional macro SERIAL_SUB7_OVF_EN adds the signed-overflow output ovf.
//
// Handshake timing: start is accepted in IDLE at edge E0. Bits 0..6 are
// processed on E1..E7, and the result is written on E7. done is high for the
// single DONE cycle between E7 and E8, after which the block returns to IDLE.
module serial_sub7 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic       busy,
    output logic       done,
    output logic [6:0] d,
`ifdef SERIAL_SUB7_OVF_EN
    output logic       ovf,
`endif
    output logic       borrow
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] a_sr_q, a_sr_d;
    logic [6:0] b_sr_q, b_sr_d;
    logic [6:0] d_sr_q, d_sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic [6:0] d_q, d_d;
    logic       borrow_q, borrow_d;
`ifdef SERIAL_SUB7_OVF_EN
    logic       a6_q, a6_d;
    logic       b6_q, b6_d;
    logic       ovf_q, ovf_d;
`endif

    // Single full-adder slice operating on the current LSBs.
    logic nb0;
    logic sum_bit;
    logic carry_out;

    // Full-adder slice: a + ~b with the running carry.
    always_comb begin
        nb0       = ~b_sr_q[0];
        sum_bit   = a_sr_q[0] ^ nb0 ^ carry_q;
        carry_out = (a_sr_q[0] & nb0) | (carry_q & (a_sr_q[0] ^ nb0));
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        d_d      = d_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB7_OVF_EN
        a6_d     = a6_q;
        b6_d     = b6_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = 1'b1;
                    cnt_d   = 3'd0;
`ifdef SERIAL_SUB7_OVF_EN
                    a6_d    = a[6];
                    b6_d    = b[6];
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                d_sr_d  = {sum_bit, d_sr_q[6:1]};
                a_sr_d  = {1'b0, a_sr_q[6:1]};
                b_sr_d  = {1'b0, b_sr_q[6:1]};
                carry_d = carry_out;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    // Last bit: publish the result on this same edge.
                    d_d      = {sum_bit, d_sr_q[6:1]};
                    borrow_d = ~carry_out;
`ifdef SERIAL_SUB7_OVF_EN
                    ovf_d    = (a6_q != b6_q) & (sum_bit != a6_q);
`endif
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            a_sr_q   <= 7'd0;
            b_sr_q   <= 7'd0;
            d_sr_q   <= 7'd0;
            cnt_q    <= 3'd0;
            carry_q  <= 1'b0;
            d_q      <= 7'd0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB7_OVF_EN
            a6_q     <= 1'b0;
            b6_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB7_OVF_EN
            a6_q     <= a6_d;
            b6_q     <= b6_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy   = (state_q == StRun);
        done   = (state_q == StDone);
        d      = d_q;
        borrow = borrow_q;
`ifdef SERIAL_SUB7_OVF_EN
        ovf    = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_sub7.sv
// Scoreboard bench for serial_sub7: stimulus pushes expected results into a
// queue and a monitor pops and compares them whenever done is seen.
module tb_serial_sub7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] a = 7'd0;
    logic [6:0] b = 7'd0;
    logic       busy;
    logic       done;
    logic [6:0] d;
    logic       borrow;
`ifdef SERIAL_SUB7_OVF_EN
    logic       ovf;
`endif

    typedef struct {
        logic [6:0] d;
        logic       br;
        logic       ov;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    serial_sub7 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .d       (d),
`ifdef SERIAL_SUB7_OVF_EN
        .ovf     (ovf),
`endif
        .borrow  (borrow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every done pulse, and police busy/done overlap.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("d", int'(d), int'(e.d));
                    chk("borrow", int'(borrow), int'(e.br));
                    chk("latency", cyc - e.acc, 7);
`ifdef SERIAL_SUB7_OVF_EN
                    chk("ovf", int'(ovf), int'(e.ov));
`endif
                end
            end
        end
    end

    // Wait (bounded) for busy to rise after start is presented, then log it.
    task automatic wait_accept(input logic [6:0] ed, input logic eb, input logic eo);
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        if (!busy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.d   = ed;
            e.br  = eb;
            e.ov  = eo;
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [6:0] aa, input logic [6:0] bb,
                         input logic [6:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        wait_accept(ed, eb, eo);
        start = 1'b0;
        // Scramble operands to show they are not re-sampled.
        a = ~aa;
        b = ~bb;
    endtask

    task automatic wait_done();
        int base;
        base = done_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_cnt != base) break;
        end
        if (done_cnt == base) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int base;
        // Reset values, checked without any clock edge having mattered.
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_borrow", int'(borrow), 0);
`ifdef SERIAL_SUB7_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors: a, b, expected d, borrow, ovf.
        issue(7'd5, 7'd3, 7'd2, 1'b0, 1'b0);
        wait_done();
        issue(7'd3, 7'd5, 7'h7E, 1'b1, 1'b0);
        wait_done();
        issue(7'h40, 7'h01, 7'h3F, 1'b0, 1'b1);
        wait_done();
        issue(7'h55, 7'h55, 7'h00, 1'b0, 1'b0);
        wait_done();
        issue(7'h00, 7'h7F, 7'h01, 1'b1, 1'b0);
        wait_done();

        // Held outputs between operations.
        repeat (3) @(negedge clk);
        chk("hold_d", int'(d), 1);
        chk("hold_borrow", int'(borrow), 1);

        // start re-asserted during RUN and DONE must be ignored.
        issue(7'd10, 7'd4, 7'd6, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 7'd0;
        b = 7'd1;
        start = 1'b1;
        base = done_cnt;
        wait_done();
        // start still held: picked up once the block is back in IDLE.
        wait_accept(7'h7F, 1'b1, 1'b0);
        start = 1'b0;
        chk("single_done_pulse", done_cnt - base, 1);
        wait_done();

        // Asynchronous reset in the middle of RUN aborts the operation.
        issue(7'd5, 7'd3, 7'd2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_borrow", int'(borrow), 0);
        exp_q.delete();
        base = done_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", done_cnt - base, 0);
        chk("idle_after_abort", int'(busy), 0);

        // Normal operation after the abort.
        issue(7'd10, 7'd4, 7'd6, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
